// File: rtl/alu_operand_loader.sv
// Switch-side operand sequencer: captures A, B and F on successive load edges and
// offers the operation to the ALU over valid/ready. Optional counter: ALU_LOADER_OPCOUNT_EN.
module alu_operand_loader #(
  parameter int NBITS       = 4,
  parameter int NFUNC       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] data_in,
  input  logic [NFUNC-1:0] func_in,
  input  logic             load,
  input  logic             clear,
  output logic [NBITS-1:0] op_a,
  output logic [NBITS-1:0] op_b,
  output logic [NFUNC-1:0] op_f,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       state_led,
  output logic             overrun,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_F     = 2'b10,
    S_ISSUE = 2'b11
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   load_p;
  logic                   commit;
  logic                   cap_a, cap_b, cap_f;
  logic                   set_valid, clr_valid, set_ovr;

  // Load synchronizer and rising-edge detect; zeroed flops make a load held
  // across reset release look like one fresh edge.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= '0;
      load_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], load};
      load_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign commit = sync_p[SYNC_STAGES-1] & ~load_p;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) state <= S_A;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    cap_f     = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      S_A: begin
        if (clear) state_nxt = S_A;
        else if (commit) begin
          cap_a     = 1'b1;
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (clear) state_nxt = S_A;
        else if (commit) begin
          cap_b     = 1'b1;
          state_nxt = S_F;
        end
      end
      S_F: begin
        if (clear) state_nxt = S_A;
        else if (commit) begin
          cap_f     = 1'b1;
          set_valid = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An edge here has no slot to go to: flag it and drop it.
        if (commit) set_ovr = 1'b1;
        if (op_valid && op_ready) begin
          clr_valid = 1'b1;
          state_nxt = S_A;
        end
        if (clear) begin
          clr_valid = 1'b1;
          state_nxt = S_A;
        end
      end
      default: state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_f     <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (cap_a) op_a <= data_in;
      if (cap_b) op_b <= data_in;
      if (cap_f) op_f <= func_in;
      if (set_valid)      op_valid <= 1'b1;
      else if (clr_valid) op_valid <= 1'b0;
      if (set_ovr) overrun <= 1'b1;
    end
  end

  assign state_led = state;

`ifdef ALU_LOADER_OPCOUNT_EN
  logic       xfer;
  logic [7:0] cnt;

  // A transfer counts whenever valid and ready meet, even if clear aborts alongside.
  assign xfer = (state == S_ISSUE) & op_valid & op_ready;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n)  cnt <= 8'h00;
    else if (xfer) cnt <= cnt + 8'd1;
  end

  assign op_count = cnt;
`else
  assign op_count = 8'h00;
`endif

endmodule
